// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard unit and its match comparator.
// Entry rd is stored at REG_AW_MAX bits; narrower register files zero-extend into it.
package hazard_pkg;

    localparam int unsigned REG_AW_MAX = 8;

    // fwd_*_sel value selecting the register file (no bypass)
    localparam int unsigned FWD_RF = 0;

    localparam int unsigned FLUSH_IFID = 0;
    localparam int unsigned FLUSH_IDEX = 1;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  wr_en;
        logic                  is_load;
    } entry_t;

    localparam entry_t ENTRY_BUBBLE = '0;

endpackage

// File: rtl/hazard_cmp.sv
// Compares one decode source register against one in-flight producer entry.
// Register 0 is hard-wired and never reported as a dependency.
module hazard_cmp
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              uses,
    input  logic [REG_AW-1:0] src,
    input  entry_t            ent,
    output logic              match
);

    logic [REG_AW_MAX-1:0] src_ext;

    assign src_ext = REG_AW_MAX'(src);

    always_comb begin
        match = uses && ent.valid && ent.wr_en && (ent.rd == src_ext) && (src != '0);
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks EX..WB producers, raises stall/flush and picks bypass sources.
// Define HAZARD_UNIT_FORWARDING_EN for bypassing (load-use stall only); else stall on any RAW.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned  REG_AW = 5,
    parameter int unsigned  DEPTH  = 3,
    parameter int unsigned  CNT_W  = 16,
    localparam int unsigned SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              redirect,
    output logic              stall,
    output logic [1:0]        flush,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    entry_t           ent_q [DEPTH];
    entry_t           ent_new;
    logic [DEPTH-1:0] rs_match;
    logic [DEPTH-1:0] rt_match;
    logic             hazard;
    logic             issue;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             unused_load;

    for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
        hazard_cmp #(
            .REG_AW (REG_AW)
        ) u_cmp_rs (
            .uses  (id_uses_rs),
            .src   (id_rs),
            .ent   (ent_q[k]),
            .match (rs_match[k])
        );

        hazard_cmp #(
            .REG_AW (REG_AW)
        ) u_cmp_rt (
            .uses  (id_uses_rt),
            .src   (id_rt),
            .ent   (ent_q[k]),
            .match (rt_match[k])
        );
    end

`ifdef HAZARD_UNIT_FORWARDING_EN
    // Only a load in EX cannot be bypassed in time; everything else forwards.
    always_comb begin
        hazard = id_valid && ent_q[0].is_load && (rs_match[0] || rt_match[0]);
    end

    // Scan oldest to youngest so the youngest producer overwrites the selection.
    always_comb begin
        fwd_rs_sel = SEL_W'(FWD_RF);
        fwd_rt_sel = SEL_W'(FWD_RF);
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (rs_match[k]) begin
                fwd_rs_sel = SEL_W'(k + 1);
            end
            if (rt_match[k]) begin
                fwd_rt_sel = SEL_W'(k + 1);
            end
        end
    end
`else
    always_comb begin
        hazard = id_valid && ((|rs_match) || (|rt_match));
    end

    always_comb begin
        fwd_rs_sel = SEL_W'(FWD_RF);
        fwd_rt_sel = SEL_W'(FWD_RF);
    end
`endif

    // Redirect wins over stall; reset drops stall without waiting for entries to clear.
    always_comb begin
        stall = hazard && !redirect && !reset;
    end

    always_comb begin
        flush             = '0;
        flush[FLUSH_IFID] = redirect;
        flush[FLUSH_IDEX] = redirect;
    end

    always_comb begin
        issue   = id_valid && !stall && !redirect;
        ent_new = ENTRY_BUBBLE;
        if (issue) begin
            ent_new.valid   = 1'b1;
            ent_new.rd      = REG_AW_MAX'(id_rd);
            ent_new.wr_en   = id_wr_en;
            ent_new.is_load = id_is_load;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                ent_q[k] <= ENTRY_BUBBLE;
            end
        end else begin
            ent_q[0] <= ent_new;
            for (int k = 1; k < int'(DEPTH); k++) begin
                ent_q[k] <= ent_q[k-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // is_load of older entries only travels down the pipe; fold it so it is visibly consumed.
    always_comb begin
        unused_load = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            unused_load = unused_load ^ ent_q[k].is_load;
        end
    end

endmodule
